// File: rtl/esm_issue_scheduler.sv
`timescale 1ns/1ps
// esm_issue_scheduler: instruction buffer slot manager.
// Allocates slots, captures each slot's dependency vector one cycle after
// allocation, offers the lowest dependency-free slot for issue through a
// locked issue register, and frees slots on completion while clearing the
// completing slot's bit from every other slot's dependency mask.
module esm_issue_scheduler #(
  parameter int BS     = 16,
  parameter int REGNUM = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  output logic [$clog2(BS)-1:0] alloc_index,
  input  logic [BS-1:0]         idt,
  output logic                  issue_valid,
  output logic [$clog2(BS)-1:0] issue_index,
  input  logic                  issue_ready,
  input  logic                  cmpl_valid,
  input  logic [$clog2(BS)-1:0] cmpl_index,
  output logic [$clog2(BS):0]   occupancy
);
  localparam int IW = $clog2(BS);

  // Elaboration-time sanity check on the sizing parameters.
  if (BS < 2 || (BS & (BS - 1)) != 0 || REGNUM < 1) begin : g_bad_param
    $error("esm_issue_scheduler: BS must be a power of 2 >= 2, REGNUM >= 1");
  end

  typedef enum logic [1:0] {FREE, CAPT, PEND, ISSUED} ent_st_e;

  ent_st_e          r_st   [BS];
  logic [BS-1:0]    r_mask [BS];
  logic             r_cap_vld;
  logic [IW-1:0]    r_cap_idx;
  logic             r_iss_vld;
  logic [IW-1:0]    r_iss_idx;
  logic [IW:0]      r_occ;

  logic [BS-1:0]    w_free;
  logic [BS-1:0]    w_ready;
  logic [BS-1:0]    w_cand;
  logic [IW-1:0]    w_alloc_idx;
  logic [IW-1:0]    w_iss_sel;
  logic             w_alloc_acc;
  logic             w_cmpl_ok;
  logic             w_iss_hs;
  logic [BS-1:0]    w_cmpl_oh;
  logic [BS-1:0]    w_cap_mask;

  // Per-slot status flags derived from registered state only.
  always_comb begin
    w_free  = '0;
    w_ready = '0;
    for (int i = 0; i < BS; i++) begin
      w_free[i]  = (r_st[i] == FREE);
      w_ready[i] = (r_st[i] == PEND) && (r_mask[i] == '0);
    end
  end

  // Lowest-numbered free slot; 0 when the buffer is full.
  always_comb begin
    w_alloc_idx = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (w_free[i]) w_alloc_idx = IW'(i);
    end
  end

  // Lowest-numbered ready slot, excluding the one already locked for issue.
  always_comb begin
    w_cand = w_ready;
    if (r_iss_vld) w_cand[r_iss_idx] = 1'b0;
    w_iss_sel = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (w_cand[i]) w_iss_sel = IW'(i);
    end
  end

  // Handshakes, and the mask written into the slot being captured this cycle.
  // A slot completing in the capture cycle is dropped from the new mask,
  // since its own clear would otherwise be lost under the capture write.
  always_comb begin
    w_alloc_acc = alloc_valid && alloc_ready;
    w_cmpl_ok   = cmpl_valid && (r_st[cmpl_index] == ISSUED);
    w_iss_hs    = r_iss_vld && issue_ready;
    w_cmpl_oh   = w_cmpl_ok ? (BS'(1) << cmpl_index) : '0;
    w_cap_mask  = idt & ~w_free & ~(BS'(1) << r_cap_idx) & ~w_cmpl_oh;
  end

  assign alloc_ready = |w_free;
  assign alloc_index = w_alloc_idx;
  assign issue_valid = r_iss_vld;
  assign issue_index = r_iss_idx;
  assign occupancy   = r_occ;

  // Slot lifecycle FREE -> CAPT -> PEND -> ISSUED -> FREE. The four
  // transitions address slots in distinct states, so they never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BS; i++) r_st[i] <= FREE;
    end else begin
      for (int i = 0; i < BS; i++) begin
        if (w_alloc_acc && (w_alloc_idx == IW'(i)))
          r_st[i] <= CAPT;
        else if (r_cap_vld && (r_cap_idx == IW'(i)))
          r_st[i] <= PEND;
        else if (w_iss_hs && (r_iss_idx == IW'(i)))
          r_st[i] <= ISSUED;
        else if (w_cmpl_ok && (cmpl_index == IW'(i)))
          r_st[i] <= FREE;
      end
    end
  end

  // Dependency masks: loaded on capture, completing slot's bit cleared in all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BS; i++) r_mask[i] <= '0;
    end else begin
      for (int i = 0; i < BS; i++) begin
        if (r_cap_vld && (r_cap_idx == IW'(i)))
          r_mask[i] <= w_cap_mask;
        else
          r_mask[i] <= r_mask[i] & ~w_cmpl_oh;
      end
    end
  end

  // Capture register: remembers which slot takes idt on the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cap_vld <= 1'b0;
      r_cap_idx <= '0;
    end else begin
      r_cap_vld <= w_alloc_acc;
      r_cap_idx <= w_alloc_idx;
    end
  end

  // Issue register: holds the offered slot stable until it is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iss_vld <= 1'b0;
      r_iss_idx <= '0;
    end else if (!r_iss_vld || w_iss_hs) begin
      r_iss_vld <= |w_cand;
      r_iss_idx <= w_iss_sel;
    end
  end

  // Occupancy tracks allocations in and valid completions out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ <= '0;
    end else begin
      unique case ({w_alloc_acc, w_cmpl_ok})
        2'b10:   r_occ <= r_occ + (IW+1)'(1);
        2'b01:   r_occ <= r_occ - (IW+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_esm_issue_scheduler.sv
`timescale 1ns/1ps
// Bench for esm_issue_scheduler: table-driven in-order issue sequence, then
// hand-written dependency, stall, full-buffer and capture/reset sequences.
// Issue order is tracked by a scoreboard queue popped on each handshake.
module tb_esm_issue_scheduler;
  localparam int BS = 16;
  localparam int IW = $clog2(BS);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alloc_valid = 1'b0;
  logic          alloc_ready;
  logic [IW-1:0] alloc_index;
  logic [BS-1:0] idt = '0;
  logic          issue_valid;
  logic [IW-1:0] issue_index;
  logic          issue_ready = 1'b0;
  logic          cmpl_valid = 1'b0;
  logic [IW-1:0] cmpl_index = '0;
  logic [IW:0]   occupancy;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  typedef struct {
    logic          av;
    logic [BS-1:0] idt;
    logic          ir;
    logic          cv;
    logic [IW-1:0] ci;
    logic          ar;
    logic [IW-1:0] ai;
    logic          iv;
    logic [IW-1:0] ii;
    logic [IW:0]   occ;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  esm_issue_scheduler #(.BS(BS), .REGNUM(32)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_index(alloc_index),
    .idt(idt),
    .issue_valid(issue_valid), .issue_index(issue_index), .issue_ready(issue_ready),
    .cmpl_valid(cmpl_valid), .cmpl_index(cmpl_index),
    .occupancy(occupancy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  // Scoreboard: every accepted issue must match the next expected slot.
  always @(negedge clk) begin
    if (rst && issue_valid && issue_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_issue: got index %0d, expected no issue", issue_index);
      end else begin
        chk("sb_issue_order", issue_index, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic av, input logic [BS-1:0] d, input logic ir,
                       input logic cv, input logic [IW-1:0] ci);
    alloc_valid = av; idt = d; issue_ready = ir; cmpl_valid = cv; cmpl_index = ci;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Asynchronous reset asserted and checked away from any clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, "_alloc_ready"}, alloc_ready, 1);
    chk({tag, "_issue_valid"}, issue_valid, 0);
    chk({tag, "_occupancy"},   occupancy,   0);
    chk({tag, "_alloc_index"}, alloc_index, 0);
    exp_q.delete();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    @(posedge clk); #3;
    rst = 1'b1;
    tick();
  endtask

  task automatic run_tbl(input int n);
    for (int k = 0; k < n; k++) begin
      drive(tbl[k].av, tbl[k].idt, tbl[k].ir, tbl[k].cv, tbl[k].ci);
      chk($sformatf("t%0d_alloc_ready", k), alloc_ready, tbl[k].ar);
      chk($sformatf("t%0d_alloc_index", k), alloc_index, tbl[k].ai);
      chk($sformatf("t%0d_issue_valid", k), issue_valid, tbl[k].iv);
      if (tbl[k].iv) chk($sformatf("t%0d_issue_index", k), issue_index, tbl[k].ii);
      chk($sformatf("t%0d_occupancy", k), occupancy, tbl[k].occ);
      tick();
    end
  endtask

  initial begin
    //        av    idt     ir    cv    ci     ar    ai     iv    ii     occ
    tbl[0] = '{1'b1, 16'h0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 5'd0};
    tbl[1] = '{1'b1, 16'h0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 4'd0, 5'd1};
    tbl[2] = '{1'b1, 16'h0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 4'd0, 5'd2};
    tbl[3] = '{1'b0, 16'h0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 4'd0, 5'd3};
    tbl[4] = '{1'b0, 16'h0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 4'd1, 5'd3};
    tbl[5] = '{1'b0, 16'h0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 4'd2, 5'd3};
    tbl[6] = '{1'b0, 16'h0, 1'b1, 1'b1, 4'd0, 1'b1, 4'd3, 1'b0, 4'd0, 5'd3};
    tbl[7] = '{1'b0, 16'h0, 1'b1, 1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 5'd2};
    tbl[8] = '{1'b0, 16'h0, 1'b1, 1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 5'd1};
    tbl[9] = '{1'b0, 16'h0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 5'd0};

    drive(1'b0, '0, 1'b0, 1'b0, '0);
    do_reset("rst0");

    // Three independent allocations issue in order, back to back.
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    run_tbl(10);
    chk("seq1_sb_drained", exp_q.size(), 0);
    do_reset("rst1");

    // B depends on A: held until A completes.
    begin
      bit seen;
      exp_q.push_back(0); exp_q.push_back(1);
      drive(1'b1, '0, 1'b0, 1'b0, '0); tick();
      drive(1'b1, '0, 1'b0, 1'b0, '0); tick();
      drive(1'b0, 16'h0001, 1'b0, 1'b0, '0); tick();
      drive(1'b0, '0, 1'b1, 1'b0, '0);
      chk("dep_a_valid", issue_valid, 1);
      chk("dep_a_index", issue_index, 0);
      tick();
      drive(1'b0, '0, 1'b1, 1'b0, '0);
      chk("dep_b_held0", issue_valid, 0);
      tick();
      drive(1'b0, '0, 1'b1, 1'b1, 4'd0);
      chk("dep_b_held1", issue_valid, 0);
      tick();
      seen = 1'b0;
      for (int c = 0; c < 2 && !seen; c++) begin
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        if (issue_valid) seen = 1'b1;
        else tick();
      end
      chk("dep_b_valid_after_cmpl", issue_valid, 1);
      chk("dep_b_index", issue_index, 1);
      tick();
      chk("dep_sb_drained", exp_q.size(), 0);
    end
    do_reset("rst2");

    // Offered slot 3 held through a stall while slot 1 becomes ready.
    exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(2);
    drive(1'b1, '0, 1'b1, 1'b0, '0); tick();
    drive(1'b1, '0, 1'b1, 1'b0, '0); tick();
    drive(1'b1, 16'h0001, 1'b1, 1'b0, '0); tick();
    drive(1'b1, 16'h0001, 1'b1, 1'b0, '0);
    chk("stall_first_index", issue_index, 0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0); tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, '0, 1'b0, (c == 0), 4'd0);
      chk($sformatf("stall_c%0d_valid", c), issue_valid, 1);
      chk($sformatf("stall_c%0d_index", c), issue_index, 3);
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("stall_accept_index", issue_index, 3);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("stall_next_index", issue_index, 1);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("stall_last_index", issue_index, 2);
    tick();
    chk("stall_sb_drained", exp_q.size(), 0);
    do_reset("rst3");

    // Fill all 16 slots, stray completions ignored, free slot 5.
    for (int k = 0; k < BS; k++) exp_q.push_back(k);
    for (int k = 0; k < BS; k++) begin
      drive(1'b1, '0, 1'b1, 1'b0, '0);
      chk($sformatf("full_alloc%0d_index", k), alloc_index, k);
      tick();
    end
    drive(1'b1, '0, 1'b1, 1'b1, 4'd15);
    chk("full_alloc_ready", alloc_ready, 0);
    chk("full_occupancy", occupancy, 16);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("full_ignored_alloc_occ", occupancy, 16);
    tick();
    drive(1'b0, '0, 1'b1, 1'b1, 4'd5);
    chk("full_same_cycle_ready", alloc_ready, 0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("freed_alloc_ready", alloc_ready, 1);
    chk("freed_alloc_index", alloc_index, 5);
    chk("freed_occupancy", occupancy, 15);
    tick();
    chk("full_sb_drained", exp_q.size(), 0);
    do_reset("rst4");

    // Capture racing a completion of a dependency, then mid-stream reset.
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    run_tbl(6);
    drive(1'b1, '0, 1'b1, 1'b0, '0);
    chk("race_alloc_index", alloc_index, 3);
    tick();
    drive(1'b0, 16'h0004, 1'b1, 1'b1, 4'd2); tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("race_occupancy", occupancy, 3);
    chk("race_freed_index", alloc_index, 2);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    chk("race_issue_valid", issue_valid, 1);
    chk("race_issue_index", issue_index, 3);
    tick();
    chk("race_sb_drained", exp_q.size(), 0);
    drive(1'b1, '0, 1'b0, 1'b0, '0);
    chk("mid_pre_occupancy", occupancy, 3);
    do_reset("rst_mid");
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    chk("post_rst_alloc_ready", alloc_ready, 1);
    chk("post_rst_occupancy", occupancy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/esm_issue_scheduler.md
ESM_ISSUE_SCHEDULER -- requirements
Module: esm_issue_scheduler

Interface
REQ-001 SHALL have parameter BS, default 16, meaning instruction buffer depth (power of 2, >=2).
REQ-002 SHALL have parameter REGNUM, default 32, meaning architectural register count (sizing only; no register ports).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port alloc_valid  input  1  new decoded instruction requests a buffer slot.
REQ-006 SHALL have port alloc_ready  output  1  a slot is free; allocation accepted when alloc_valid & alloc_ready.
REQ-007 SHALL have port alloc_index  output  $clog2(BS)  slot granted; drives the dependency table's buffer_index.
REQ-008 SHALL have port idt  input  BS  dependency vector from the dependency table, valid the cycle after an accepted allocation.
REQ-009 SHALL have port issue_valid  output  1  a dependency-free entry is offered for issue.
REQ-010 SHALL have port issue_index  output  $clog2(BS)  slot being offered.
REQ-011 SHALL have port issue_ready  input  1  execution side accepts the offered entry.
REQ-012 SHALL have port cmpl_valid  input  1  an issued entry has completed.
REQ-013 SHALL have port cmpl_index  input  $clog2(BS)  slot of the completing entry.
REQ-014 SHALL have port occupancy  output  $clog2(BS)+1  count of non-FREE entries.

Function
REQ-015 SHALL hold per entry a state in {FREE, CAPT, PEND, ISSUED} and a BS-bit dependency mask.
REQ-016 SHALL drive alloc_ready = any entry FREE; alloc_index = lowest-numbered FREE entry (combinational from registered state).
REQ-017 SHALL on accepted allocation move that entry FREE->CAPT and register its index in a capture register with a capture-valid flag.
REQ-018 SHALL in the cycle after allocation load the captured entry's mask with idt AND (entries non-FREE) AND NOT(self bit) AND NOT(cmpl bit if cmpl_valid that cycle), and move it CAPT->PEND.
REQ-019 SHALL support back-to-back allocation every cycle; capture of entry N and allocation of entry N+1 occur in the same cycle.
REQ-020 SHALL treat a PEND entry with all-zero mask as ready; ready is evaluated from registered mask, so earliest issue is two cycles after allocation.
REQ-021 SHALL select the lowest-numbered ready entry, lock it in an issue register, and hold issue_valid/issue_index stable until issue_valid & issue_ready.
REQ-022 SHALL on issue handshake move the locked entry PEND->ISSUED and allow a new selection offered the next cycle (one issue per cycle max when ready held high).
REQ-023 SHALL on cmpl_valid with the addressed entry ISSUED: set it FREE and clear bit cmpl_index in every entry's mask, effective next cycle.
REQ-024 SHALL ignore cmpl_valid addressing an entry not in ISSUED (no state or mask change).
REQ-025 SHALL make a slot freed by completion allocatable in the following cycle, not the same cycle.
REQ-026 SHALL ignore idt in cycles with no capture pending.
REQ-027 SHALL update occupancy = occupancy + alloc_accept - valid_completion each cycle; alloc and completion in the same cycle leave it unchanged.
REQ-028 SHALL deassert alloc_ready when occupancy = BS and ignore alloc_valid then.

Reset
REQ-029 SHALL on rst low, immediately and asynchronously: all entries FREE, masks 0, capture and issue registers invalid, issue_valid=0, occupancy=0, alloc_index=0.
REQ-030 SHALL drive alloc_ready=1 from the first rising edge after rst deasserts; an allocation in flight or locked issue at reset is discarded.

Verification
REQ-031 SHALL cover: rst low then high -> alloc_ready=1, issue_valid=0, occupancy=0, alloc_index=0.
REQ-032 SHALL cover: 3 allocations, idt=0 each, issue_ready=1 -> alloc_index 0,1,2; issue_index 0,1,2 on consecutive cycles starting 2 cycles after first alloc.
REQ-033 SHALL cover: alloc A (idx0), B (idx1) with idt=16'h0001, issue A -> B held; cmpl_index=0 -> issue_valid with issue_index=1 the cycle after completion.
REQ-034 SHALL cover: issue_ready=0 for 4 cycles while idx3 offered and idx1 becomes ready -> issue_index stays 3 until accepted, then 1.
REQ-035 SHALL cover: 16 allocations -> alloc_ready=0, occupancy=16; complete idx5 -> next cycle alloc_ready=1, alloc_index=5, occupancy=15.
REQ-036 SHALL cover: capture with idt bit 2 set while cmpl_index=2 same cycle -> captured mask bit 2 = 0, entry issuable next cycle; rst asserted mid-stream -> all outputs reset without a clock edge.
